// File: rtl/iteration_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : iteration_scheduler_if
// Description : Control and per-core report bundle of the iteration scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface iteration_scheduler_if #(
  parameter int CORE_NUM   = 32,
  parameter int ITER_WIDTH = 8,
  parameter int CNT_WIDTH  = 24
);
  logic                  start;
  logic                  abort;
  logic [CORE_NUM-1:0]   iteration_end;
  logic [CORE_NUM-1:0]   iteration_end_valid;
  logic [CORE_NUM-1:0]   active_v_updated;
  logic [CORE_NUM-1:0]   active_v_valid;
  logic                  iteration_start;
  logic [ITER_WIDTH-1:0] iteration_id;
  logic                  pull_mode;
  logic                  busy;
  logic                  done;
  logic [CNT_WIDTH-1:0]  update_count;

  modport master (
    output start, abort, iteration_end, iteration_end_valid, active_v_updated, active_v_valid,
    input  iteration_start, iteration_id, pull_mode, busy, done, update_count
  );

  modport slave (
    input  start, abort, iteration_end, iteration_end_valid, active_v_updated, active_v_valid,
    output iteration_start, iteration_id, pull_mode, busy, done, update_count
  );
endinterface
`default_nettype wire

// File: rtl/iteration_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : iteration_scheduler
// Description : Sequences graph-engine iterations, gathers per-core end and
//               update reports, picks push/pull mode and detects convergence.
// Revision    : 1.0 - initial release
// ============================================================================
module iteration_scheduler #(
  parameter int CORE_NUM       = 32,
  parameter int ITER_WIDTH     = 8,
  parameter int MAX_ITER       = 64,
  parameter int CNT_WIDTH      = 24,
  parameter int PULL_THRESHOLD = 4096
) (
  input  wire logic             clk,
  input  wire logic             rst,
  iteration_scheduler_if.slave  bus
);

  localparam int c_pop_w = $clog2(CORE_NUM + 1);
  localparam int c_sum_w = ((CNT_WIDTH > c_pop_w) ? CNT_WIDTH : c_pop_w) + 1;
  localparam logic [CNT_WIDTH-1:0]  c_cnt_max   = '1;
  localparam logic [ITER_WIDTH-1:0] c_last_iter = ITER_WIDTH'(MAX_ITER - 1);
  localparam logic [63:0]           c_pull_thr  = 64'(PULL_THRESHOLD);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_EVAL  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  logic [CORE_NUM-1:0]   r_flags;
  logic [CNT_WIDTH-1:0]  r_acc;
  logic                  r_iteration_start;
  logic [ITER_WIDTH-1:0] r_iteration_id;
  logic                  r_pull_mode;
  logic                  r_busy;
  logic                  r_done;
  logic [CNT_WIDTH-1:0]  r_update_count;

  logic [CORE_NUM-1:0]   w_flags_next;
  logic                  w_all_end;
  logic [c_pop_w-1:0]    w_pop;
  logic [c_sum_w-1:0]    w_sum;
  logic [CNT_WIDTH-1:0]  w_acc_next;

  // Flags set in the current cycle already count toward completion.
  always_comb begin
    w_flags_next = r_flags | (bus.iteration_end_valid & bus.iteration_end);
    w_all_end    = &w_flags_next;
    w_pop        = '0;
    for (int i = 0; i < CORE_NUM; i++) begin
      w_pop = w_pop + c_pop_w'(bus.active_v_valid[i] & bus.active_v_updated[i]);
    end
    w_sum      = c_sum_w'(r_acc) + c_sum_w'(w_pop);
    w_acc_next = (w_sum > c_sum_w'(c_cnt_max)) ? c_cnt_max : w_sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state           <= S_IDLE;
      r_flags           <= '0;
      r_acc             <= '0;
      r_iteration_start <= 1'b0;
      r_iteration_id    <= '0;
      r_pull_mode       <= 1'b0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_update_count    <= '0;
    end else if ((r_state != S_IDLE) && bus.abort) begin
      r_state           <= S_IDLE;
      r_flags           <= '0;
      r_acc             <= '0;
      r_iteration_start <= 1'b0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
    end else begin
      r_iteration_start <= 1'b0;
      r_done            <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            r_state           <= S_START;
            r_iteration_start <= 1'b1;
            r_busy            <= 1'b1;
            r_iteration_id    <= '0;
            r_pull_mode       <= 1'b0;
          end
        end
        S_START: begin
          r_flags <= '0;
          r_acc   <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          r_flags <= w_flags_next;
          r_acc   <= w_acc_next;
          if (w_all_end) begin
            r_state <= S_EVAL;
          end
        end
        S_EVAL: begin
          r_update_count <= r_acc;
          if ((r_acc == '0) || (r_iteration_id == c_last_iter)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_iteration_id    <= r_iteration_id + ITER_WIDTH'(1);
            r_pull_mode       <= (64'(r_acc) > c_pull_thr);
            r_state           <= S_START;
            r_iteration_start <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.iteration_start = r_iteration_start;
  assign bus.iteration_id    = r_iteration_id;
  assign bus.pull_mode       = r_pull_mode;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.update_count    = r_update_count;

endmodule
`default_nettype wire

// File: tb/tb_iteration_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_iteration_scheduler
// Description : Randomized self-checking bench for iteration_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iteration_scheduler;

  localparam int CORE_NUM       = 8;
  localparam int ITER_WIDTH     = 8;
  localparam int MAX_ITER       = 6;
  localparam int CNT_WIDTH      = 10;
  localparam int PULL_THRESHOLD = 20;
  localparam int CNT_MAX        = (1 << CNT_WIDTH) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  iteration_scheduler_if #(.CORE_NUM(CORE_NUM), .ITER_WIDTH(ITER_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  iteration_scheduler #(
    .CORE_NUM(CORE_NUM), .ITER_WIDTH(ITER_WIDTH), .MAX_ITER(MAX_ITER),
    .CNT_WIDTH(CNT_WIDTH), .PULL_THRESHOLD(PULL_THRESHOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start               = 1'b0;
    bus.abort               = 1'b0;
    bus.iteration_end       = '0;
    bus.iteration_end_valid = '0;
    bus.active_v_updated    = '0;
    bus.active_v_valid      = '0;
  endtask

  // Everything asserted: must have no effect outside RUN.
  task automatic junk_inputs();
    bus.start               = 1'($urandom % 2);
    bus.abort               = 1'b0;
    bus.iteration_end       = '1;
    bus.iteration_end_valid = '1;
    bus.active_v_updated    = '1;
    bus.active_v_valid      = '1;
  endtask

  task automatic check_zero_outputs(input string pfx);
    check_val({pfx, "_istart"}, bus.iteration_start, 0);
    check_val({pfx, "_id"},     bus.iteration_id,    0);
    check_val({pfx, "_pull"},   bus.pull_mode,       0);
    check_val({pfx, "_busy"},   bus.busy,            0);
    check_val({pfx, "_done"},   bus.done,            0);
    check_val({pfx, "_count"},  bus.update_count,    0);
  endtask

  // Called in the START cycle; leaves the bench one cycle after EVAL.
  task automatic drive_iter(input int n_upd, input bit stagger, output int acc);
    int len, need, last, remaining, k, lo, hi, total, j, tmp;
    int end_at[CORE_NUM];
    int idx[CORE_NUM];
    logic [CORE_NUM-1:0] ev, ee, vv, uu;
    junk_inputs();
    step();
    need = (n_upd + CORE_NUM - 1) / CORE_NUM;
    len  = stagger ? 21 : int'($urandom_range(1, 5));
    if (len < need) len = need;
    last = stagger ? CORE_NUM - 1 : int'($urandom_range(0, CORE_NUM - 1));
    for (int i = 0; i < CORE_NUM; i++)
      end_at[i] = (i == last) ? len - 1 : (stagger ? 0 : int'($urandom_range(0, len - 1)));
    remaining = n_upd;
    total     = 0;
    for (int c = 0; c < len; c++) begin
      for (int i = 0; i < CORE_NUM; i++) begin
        ev[i] = ($urandom_range(0, 2) == 0);
        ee[i] = 1'($urandom % 2);
        if (c == end_at[i]) begin
          ev[i] = 1'b1;
          ee[i] = 1'b1;
        end else if (i == last && c < end_at[i]) begin
          ee[i] = ee[i] & ~ev[i];
        end
      end
      hi = (remaining < CORE_NUM) ? remaining : CORE_NUM;
      lo = remaining - (len - 1 - c) * CORE_NUM;
      if (lo < 0) lo = 0;
      k = int'($urandom_range(lo, hi));
      for (int i = 0; i < CORE_NUM; i++) idx[i] = i;
      for (int i = 0; i < CORE_NUM; i++) begin
        j = int'($urandom_range(i, CORE_NUM - 1));
        tmp = idx[i]; idx[i] = idx[j]; idx[j] = tmp;
      end
      vv = '0;
      uu = '0;
      for (int i = 0; i < CORE_NUM; i++) begin
        if (i < k) begin
          vv[idx[i]] = 1'b1;
          uu[idx[i]] = 1'b1;
        end else begin
          case ($urandom % 3)
            1: vv[idx[i]] = 1'b1;
            2: uu[idx[i]] = 1'b1;
            default: ;
          endcase
        end
      end
      remaining -= k;
      total     += k;
      bus.iteration_end       = ee;
      bus.iteration_end_valid = ev;
      bus.active_v_updated    = uu;
      bus.active_v_valid      = vv;
      bus.start               = 1'($urandom % 2);
      bus.abort               = 1'b0;
      step();
      check_val("run_istart", bus.iteration_start, 0);
      check_val("run_done",   bus.done,            0);
      check_val("run_busy",   bus.busy,            1);
    end
    acc = (total > CNT_MAX) ? CNT_MAX : total;
    junk_inputs();
    step();
  endtask

  function automatic int plan(input int mode, input int it);
    int r;
    case (mode)
      1: return (it == 0) ? 5 : 0;
      2: return (it == 0) ? 3 : 0;
      3: return PULL_THRESHOLD + 1;
      4: return (it == 0) ? 2000 : 0;
      default: begin
        r = int'($urandom_range(0, 9));
        if (r == 0) return 0;
        if (r == 1) return PULL_THRESHOLD;
        if (r == 2) return PULL_THRESHOLD + 1;
        return int'($urandom_range(1, 40));
      end
    endcase
  endfunction

  task automatic run_sched(input int mode);
    int acc, exp_id;
    bit exp_pull;
    idle_inputs();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_val("first_istart", bus.iteration_start, 1);
    check_val("first_id",     bus.iteration_id,    0);
    check_val("first_pull",   bus.pull_mode,       0);
    check_val("first_busy",   bus.busy,            1);
    exp_id = 0;
    for (int it = 0; it < MAX_ITER; it++) begin
      drive_iter(plan(mode, it), (mode == 2) && (it == 0), acc);
      check_val("upd_count", bus.update_count, acc);
      if (acc == 0 || exp_id == MAX_ITER - 1) begin
        check_val("end_done",   bus.done,            1);
        check_val("end_istart", bus.iteration_start, 0);
        check_val("end_id",     bus.iteration_id,    exp_id);
        junk_inputs();
        step();
        check_val("idle_done", bus.done,         0);
        check_val("idle_busy", bus.busy,         0);
        check_val("idle_id",   bus.iteration_id, exp_id);
        idle_inputs();
        break;
      end
      exp_id++;
      exp_pull = (acc > PULL_THRESHOLD);
      check_val("next_istart", bus.iteration_start, 1);
      check_val("next_id",     bus.iteration_id,    exp_id);
      check_val("next_pull",   bus.pull_mode,       exp_pull);
      check_val("next_done",   bus.done,            0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    idle_inputs();
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_zero_outputs("rst");
    rst = 1'b1;
    repeat (3) step();
    check_val("idle_hold_busy",   bus.busy,            0);
    check_val("idle_hold_istart", bus.iteration_start, 0);

    run_sched(1);
    run_sched(2);
    run_sched(4);
    run_sched(3);

    // abort in RUN: straight to IDLE, no done, update_count kept
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check_val("ab_istart", bus.iteration_start, 1);
    junk_inputs();
    step();
    idle_inputs();
    bus.active_v_valid         = '1;
    bus.active_v_updated       = '1;
    bus.iteration_end_valid[0] = 1'b1;
    bus.iteration_end[0]       = 1'b1;
    step();
    idle_inputs();
    bus.abort = 1'b1;
    bus.start = 1'b1;
    step();
    idle_inputs();
    check_val("ab_busy",   bus.busy,            0);
    check_val("ab_done",   bus.done,            0);
    check_val("ab_istart", bus.iteration_start, 0);
    check_val("ab_count",  bus.update_count,    PULL_THRESHOLD + 1);
    step();
    check_val("ab_stay_done", bus.done, 0);
    check_val("ab_stay_busy", bus.busy, 0);

    // abort in START
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check_val("abs_busy",   bus.busy,            0);
    check_val("abs_istart", bus.iteration_start, 0);
    step();
    check_val("abs_done", bus.done, 0);

    // start and abort together in IDLE
    bus.start = 1'b1;
    bus.abort = 1'b1;
    step();
    idle_inputs();
    check_val("sa_busy",   bus.busy,            0);
    check_val("sa_istart", bus.iteration_start, 0);

    // asynchronous reset in the middle of iteration 1
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    drive_iter(PULL_THRESHOLD + 1, 1'b0, acc);
    check_val("rr_istart", bus.iteration_start, 1);
    check_val("rr_id",     bus.iteration_id,    1);
    check_val("rr_pull",   bus.pull_mode,       1);
    check_val("rr_count",  bus.update_count,    acc);
    junk_inputs();
    step();
    idle_inputs();
    bus.active_v_valid   = '1;
    bus.active_v_updated = '1;
    step();
    #2;
    rst = 1'b0;
    #1;
    check_zero_outputs("arst");
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    check_val("arst_after_done", bus.done, 0);
    check_val("arst_after_busy", bus.busy, 0);

    repeat (15) run_sched(0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
